// File: rtl/spi_apb_pkg.sv
// Shared constants for the SPI APB register front-end: register offsets,
// FIFO-access FSM states and interrupt event bit positions.
package spi_apb_pkg;

  localparam logic [5:0] REG_CTRL   = 6'h00;
  localparam logic [5:0] REG_CLKDIV = 6'h04;
  localparam logic [5:0] REG_CMD    = 6'h08;
  localparam logic [5:0] REG_ADR    = 6'h0C;
  localparam logic [5:0] REG_LEN    = 6'h10;
  localparam logic [5:0] REG_DUM    = 6'h14;
  localparam logic [5:0] REG_TXFIFO = 6'h18;
  localparam logic [5:0] REG_RXFIFO = 6'h20;
  localparam logic [5:0] REG_INTCFG = 6'h24;
  localparam logic [5:0] REG_INTSTA = 6'h28;

  localparam int EVT_TX_TH = 0;
  localparam int EVT_RX_TH = 1;
  localparam int EVT_DONE  = 2;
  localparam int NUM_EVT   = 3;

  typedef enum logic {
    IDLE,
    WAIT
  } fifo_state_e;

  function automatic logic is_mapped(input logic [5:0] off);
    case (off)
      REG_CTRL, REG_CLKDIV, REG_CMD, REG_ADR, REG_LEN, REG_DUM,
      REG_TXFIFO, REG_RXFIFO, REG_INTCFG, REG_INTSTA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Transfer-shaping registers that must not change under a running transfer.
  function automatic logic is_lockable(input logic [5:0] off);
    case (off)
      REG_CLKDIV, REG_CMD, REG_ADR, REG_LEN, REG_DUM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_apb_irq.sv
// Interrupt status latch: events set INTSTA bits, W1C clears them (set wins),
// and the masked, globally enabled OR drives a registered IRQ line.
module spi_apb_irq
  import spi_apb_pkg::*;
(
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [NUM_EVT-1:0] evt,
  input  logic [NUM_EVT-1:0] w1c,
  input  logic [NUM_EVT-1:0] mask,
  input  logic               en,
  output logic [NUM_EVT-1:0] intsta,
  output logic               irq
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // irq therefore follows intsta with exactly one cycle of delay.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      intsta <= '0;
      irq    <= 1'b0;
    end else begin
      intsta <= (intsta & ~w1c) | evt;
      irq    <= en & |(intsta & mask);
    end
  end

endmodule

// File: rtl/spi_apb_regs_mc.sv
// APB3 register front-end for the multi-chip-select SPI master with wait-state
// FIFO access, error responses, busy lock and interrupts.
// Define SPI_APB_TIMEOUT_EN to bound FIFO wait states by WAIT_TIMEOUT.
module spi_apb_regs_mc
  import spi_apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_CS         = 4,
  parameter int BUFFER_DEPTH   = 16,
  parameter int WAIT_TIMEOUT   = 255,
  localparam int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [15:0]               spi_clk_div,
  output logic                      spi_clk_div_valid,
  output logic [31:0]               spi_cmd,
  output logic [31:0]               spi_addr,
  output logic [5:0]                spi_cmd_len,
  output logic [5:0]                spi_addr_len,
  output logic [15:0]               spi_data_len,
  output logic [15:0]               spi_dummy_rd,
  output logic [15:0]               spi_dummy_wr,
  output logic [NUM_CS-1:0]         spi_csreg,
  output logic                      spi_rd,
  output logic                      spi_wr,
  output logic                      spi_qrd,
  output logic                      spi_qwr,
  output logic                      spi_swrst,
  input  logic                      spi_busy,
  input  logic [31:0]               spi_status,
  input  logic [2:0]                spi_evt,
  output logic [LOG_BUFFER_DEPTH:0] spi_int_th_tx,
  output logic [LOG_BUFFER_DEPTH:0] spi_int_th_rx,
  output logic                      spi_irq,
  output logic [31:0]               spi_data_tx,
  output logic                      spi_data_tx_valid,
  input  logic                      spi_data_tx_ready,
  input  logic [31:0]               spi_data_rx,
  input  logic                      spi_data_rx_valid,
  output logic                      spi_data_rx_ready
);

  logic [5:0]         reg_off;
  logic               access, wr_acc, rd_acc;
  logic               tx_acc, rx_acc, fifo_acc, fifo_ready;
  logic               illegal, lock_err, timeout_hit, commit;
  logic [NUM_EVT-1:0] int_mask, intsta, w1c;
  logic               int_en;
  logic [31:0]        intcfg_rd;
  fifo_state_e        state, state_nxt;

  assign reg_off = {PADDR[5:2], 2'b00};
  assign access  = PSEL & PENABLE;
  assign wr_acc  = access & PWRITE;
  assign rd_acc  = access & ~PWRITE;

  assign tx_acc     = wr_acc & (reg_off == REG_TXFIFO);
  assign rx_acc     = rd_acc & (reg_off == REG_RXFIFO);
  assign fifo_acc   = tx_acc | rx_acc;
  assign fifo_ready = (tx_acc & spi_data_tx_ready) | (rx_acc & spi_data_rx_valid);

  assign illegal  = access & (~is_mapped(reg_off)
                            | ((reg_off == REG_TXFIFO) & ~PWRITE)
                            | ((reg_off == REG_RXFIFO) &  PWRITE));
  // swrst (bit4) and csreg stay writable while busy; start bits do not.
  assign lock_err = wr_acc & spi_busy & (is_lockable(reg_off)
                  | ((reg_off == REG_CTRL) & |PWDATA[3:0]));

  assign PREADY  = ~fifo_acc | fifo_ready | timeout_hit;
  assign PSLVERR = access & (illegal | lock_err | timeout_hit);
  assign commit  = wr_acc & PREADY & ~PSLVERR;

  // Stream strobes are suppressed under reset so an aborted wait never hands off data.
  assign spi_data_tx       = PWDATA;
  assign spi_data_tx_valid = tx_acc & ~timeout_hit & ~HRESET;
  assign spi_data_rx_ready = rx_acc & spi_data_rx_valid & ~timeout_hit & ~HRESET;

`ifdef SPI_APB_TIMEOUT_EN
  logic [15:0] wait_cnt, wait_cnt_nxt;

  // wait_cnt_nxt counts wait cycles including the current one.
  assign wait_cnt_nxt = wait_cnt + 16'd1;
  assign timeout_hit  = (state == WAIT) && (wait_cnt_nxt == 16'(WAIT_TIMEOUT));

  always_ff @(posedge HCLK) begin
    if (HRESET || state == IDLE) wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt_nxt;
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(WAIT_TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fifo_acc && !fifo_ready) state_nxt = WAIT;
      WAIT: if (!fifo_acc || fifo_ready || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      spi_clk_div       <= '0;
      spi_clk_div_valid <= 1'b0;
      spi_cmd           <= '0;
      spi_addr          <= '0;
      spi_cmd_len       <= '0;
      spi_addr_len      <= '0;
      spi_data_len      <= '0;
      spi_dummy_rd      <= '0;
      spi_dummy_wr      <= '0;
      spi_csreg         <= '0;
      spi_rd            <= 1'b0;
      spi_wr            <= 1'b0;
      spi_qrd           <= 1'b0;
      spi_qwr           <= 1'b0;
      spi_swrst         <= 1'b0;
      spi_int_th_tx     <= '0;
      spi_int_th_rx     <= '0;
      int_mask          <= '0;
      int_en            <= 1'b0;
    end else begin
      spi_clk_div_valid <= 1'b0;
      spi_rd            <= 1'b0;
      spi_wr            <= 1'b0;
      spi_qrd           <= 1'b0;
      spi_qwr           <= 1'b0;
      spi_swrst         <= 1'b0;
      if (commit) begin
        case (reg_off)
          REG_CTRL: begin
            spi_rd    <= PWDATA[0];
            spi_wr    <= PWDATA[1];
            spi_qrd   <= PWDATA[2];
            spi_qwr   <= PWDATA[3];
            spi_swrst <= PWDATA[4];
            spi_csreg <= PWDATA[8 +: NUM_CS];
          end
          REG_CLKDIV: begin
            spi_clk_div       <= PWDATA[15:0];
            spi_clk_div_valid <= 1'b1;
          end
          REG_CMD: spi_cmd  <= PWDATA;
          REG_ADR: spi_addr <= PWDATA;
          REG_LEN: begin
            spi_cmd_len  <= PWDATA[5:0];
            spi_addr_len <= PWDATA[13:8];
            spi_data_len <= PWDATA[31:16];
          end
          REG_DUM: begin
            spi_dummy_rd <= PWDATA[15:0];
            spi_dummy_wr <= PWDATA[31:16];
          end
          REG_INTCFG: begin
            spi_int_th_tx <= PWDATA[LOG_BUFFER_DEPTH:0];
            spi_int_th_rx <= PWDATA[8+LOG_BUFFER_DEPTH:8];
            int_mask      <= PWDATA[18:16];
            int_en        <= PWDATA[31];
          end
          default: ;
        endcase
      end
    end
  end

  assign w1c = (commit && reg_off == REG_INTSTA) ? PWDATA[NUM_EVT-1:0] : '0;

  spi_apb_irq u_irq (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .evt    (spi_evt),
    .w1c    (w1c),
    .mask   (int_mask),
    .en     (int_en),
    .intsta (intsta),
    .irq    (spi_irq)
  );

  always_comb begin
    intcfg_rd                             = '0;
    intcfg_rd[LOG_BUFFER_DEPTH:0]         = spi_int_th_tx;
    intcfg_rd[8+LOG_BUFFER_DEPTH:8]       = spi_int_th_rx;
    intcfg_rd[18:16]                      = int_mask;
    intcfg_rd[31]                         = int_en;
  end

  always_comb begin
    PRDATA = '0;
    if (rd_acc && !PSLVERR) begin
      case (reg_off)
        REG_CTRL:   PRDATA = spi_status;
        REG_CLKDIV: PRDATA = {16'h0000, spi_clk_div};
        REG_CMD:    PRDATA = spi_cmd;
        REG_ADR:    PRDATA = spi_addr;
        REG_LEN:    PRDATA = {spi_data_len, 2'b00, spi_addr_len, 2'b00, spi_cmd_len};
        REG_DUM:    PRDATA = {spi_dummy_wr, spi_dummy_rd};
        REG_RXFIFO: if (spi_data_rx_ready) PRDATA = spi_data_rx;
        REG_INTCFG: PRDATA = intcfg_rd;
        REG_INTSTA: PRDATA = {{(32-NUM_EVT){1'b0}}, intsta};
        default:    PRDATA = '0;
      endcase
    end
  end

  logic unused_addr;
  assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};

endmodule

// File: doc/spi_apb_regs_mc.md
# spi_apb_regs_mc

Parametrised APB3 register front-end for the multi-chip-select SPI master. It replaces the zero-wait-state register interface with four additions:
- wait-state FIFO access with an optional timeout;
- error responses on illegal accesses;
- a configuration lock while a transfer is in progress;
- a latched, maskable interrupt status register with a single IRQ line.

It sits between the APB fabric and the SPI controller/FIFO pair.

## Interface
Parameters:
- APB_ADDR_WIDTH, 12: APB address width; only PADDR[5:2] is decoded.
- NUM_CS, 4: number of chip selects, 1..8.
- BUFFER_DEPTH, 16: FIFO depth. LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH) is a localparam.
- WAIT_TIMEOUT, 255: maximum number of wait cycles on a FIFO access, 1..65535.

Ports (one clock; reset is synchronous and active-high):
- HCLK  in  1  system clock.
- HRESET  in  1  synchronous active-high reset.
- PADDR  in  APB_ADDR_WIDTH; PWDATA  in  32; PWRITE, PSEL, PENABLE  in  1  APB3 request.
- PRDATA  out  32; PREADY  out  1; PSLVERR  out  1  APB3 response.
- spi_clk_div  out  16  clock divider; spi_clk_div_valid  out  1  one-cycle pulse on CLKDIV write.
- spi_cmd, spi_addr  out  32; spi_cmd_len, spi_addr_len  out  6; spi_data_len, spi_dummy_rd, spi_dummy_wr  out  16.
- spi_csreg  out  NUM_CS  one-hot chip-select request.
- spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst  out  1  one-cycle start/reset pulses.
- spi_busy  in  1  controller transfer in progress.
- spi_status  in  32  controller status word.
- spi_evt  in  3  one-cycle events: {done, rx_th, tx_th}.
- spi_int_th_tx, spi_int_th_rx  out  LOG_BUFFER_DEPTH+1  FIFO thresholds.
- spi_irq  out  1  interrupt line.
- spi_data_tx  out  32; spi_data_tx_valid  out  1; spi_data_tx_ready  in  1  TX stream.
- spi_data_rx  in  32; spi_data_rx_valid  in  1; spi_data_rx_ready  out  1  RX stream.

## Operation
Register map (byte offset):
- 0x00 CTRL/STATUS. Write: bit0 rd, bit1 wr, bit2 qrd, bit3 qwr, bit4 swrst, bits[8+NUM_CS-1:8] csreg. Read: spi_status.
- 0x04 CLKDIV, bits[15:0].
- 0x08 CMD.
- 0x0C ADR.
- 0x10 LEN: [5:0] cmd_len, [13:8] addr_len, [31:16] data_len.
- 0x14 DUM: [15:0] dummy_rd, [31:16] dummy_wr.
- 0x18 TXFIFO, write only.
- 0x20 RXFIFO, read only.
- 0x24 INTCFG: [LOG:0] th_tx, [8+LOG:8] th_rx, [18:16] evt mask, [31] global enable.
- 0x28 INTSTA: [2:0] latched events; writing 1 clears a bit (W1C).

Access rules:
- Every other offset, a read of TXFIFO, or a write of RXFIFO completes with PSLVERR=1 and PRDATA=0, and changes no state.
- Lock: a write to CLKDIV, CMD, ADR, LEN or DUM while spi_busy=1 returns PSLVERR=1 and leaves the register unchanged. A write to CTRL while spi_busy=1 is allowed only with bits[3:0]=0; otherwise it returns PSLVERR=1. swrst is always accepted.
- A register write commits on the HCLK edge where PSEL & PENABLE & PWRITE & PREADY & !PSLVERR.
- Pulse outputs are high for exactly the one cycle after commit, then return to 0.

Interrupts:
- INTSTA[i] is set by spi_evt[i] and cleared by W1C. Set wins when both happen in the same cycle.
- spi_irq = INTCFG[31] & |(INTSTA & mask), registered (one cycle after INTSTA changes).

FIFO access state machine, states IDLE and WAIT:
- IDLE: on an access phase to TXFIFO (write) or RXFIFO (read), the access completes immediately if the stream partner is ready (tx_ready, resp. rx_valid). Otherwise the FSM goes to WAIT and the wait counter is cleared.
- WAIT: PREADY=0 and the counter increments every cycle. Exit to IDLE on the partner handshake (PREADY=1, PSLVERR=0) or on timeout (see Configuration).
- spi_data_tx_valid = access phase to TXFIFO & PWRITE & FSM not timing out. spi_data_tx = PWDATA.
- spi_data_rx_ready = access phase to RXFIFO & !PWRITE & spi_data_rx_valid. PRDATA = spi_data_rx in that cycle.
- A handshake occurs exactly once per APB access, so no data word is duplicated or dropped on success.

## Timing
- Register accesses have zero wait states: PREADY=1 combinationally in the access phase.
- A FIFO access with its partner ready also has zero wait states. Otherwise it takes N+1 access-phase cycles, where N is the number of cycles the partner is not ready.
- Reset values: every config output 0; spi_csreg 0; all pulses 0; INTSTA 0; spi_irq 0; FSM IDLE; counter 0.
- PREADY=1 and PSLVERR=0 whenever PSEL=0.
- Reset asserted mid-WAIT: on the next edge the FSM returns to IDLE and no stream handshake is issued. The APB master must restart its transaction.
- If PSEL drops during WAIT (a protocol violation), the FSM returns to IDLE.

## Configuration
- SPI_APB_TIMEOUT_EN defined: when the counter reaches WAIT_TIMEOUT in WAIT, that cycle completes with PREADY=1 and PSLVERR=1. spi_data_tx_valid and spi_data_rx_ready are held 0 in that cycle, and PRDATA=0.
- SPI_APB_TIMEOUT_EN undefined: there is no counter and WAIT persists until the handshake. WAIT_TIMEOUT is ignored.

## Structure
- Package spi_apb_pkg holds:
  - register offset constants (REG_CTRL … REG_INTSTA);
  - the FSM state enum (IDLE, WAIT);
  - the INTSTA bit index constants (EVT_TX_TH=0, EVT_RX_TH=1, EVT_DONE=2).
- One sub-module, spi_apb_irq, contains the INTSTA latch, the W1C logic, masking and the registered spi_irq.

## Test plan
- Write CLKDIV=0x0123 with spi_busy=0 -> spi_clk_div=0x0123, one-cycle spi_clk_div_valid, PSLVERR=0. Repeat with spi_busy=1 -> PSLVERR=1, value unchanged.
- TXFIFO write 0xDEADBEEF with tx_ready low for 5 cycles -> PREADY low 5 cycles, then exactly one valid&ready handshake carrying 0xDEADBEEF.
- With timeout enabled and WAIT_TIMEOUT=8, RXFIFO read while rx_valid stays 0 -> PREADY=1, PSLVERR=1 on the 9th access cycle, rx_ready never asserted.
- spi_evt=3'b100 with mask=3'b100 and enable=1 -> INTSTA=0x4, spi_irq=1 one cycle later. W1C 0x4 in the same cycle as a new done event -> INTSTA stays 0x4.
- Read offset 0x1C and write offset 0x20 -> PSLVERR=1, PRDATA=0, no state change.
- Assert HRESET during WAIT on a TXFIFO write -> FSM IDLE, all outputs at reset values, no tx handshake.
